// File: rtl/instruction_fifo.sv
// Dual-ported instruction queue between fetch and the two decode slots.
// Accepts up to two (PC, instruction) pairs per cycle and retires up to two from the head.
module instruction_fifo #(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid_0,
  input  logic [31:0]      in_pc_0,
  input  logic [31:0]      in_inst_0,
  input  logic             in_valid_1,
  input  logic [31:0]      in_pc_1,
  input  logic [31:0]      in_inst_1,
  output logic             almost_full,
  output logic             out_valid_0,
  output logic [31:0]      out_pc_0,
  output logic [31:0]      out_inst_0,
  output logic             out_valid_1,
  output logic [31:0]      out_pc_1,
  output logic [31:0]      out_inst_1,
  input  logic             pop_0,
  input  logic             pop_1,
  output logic [PTR_W:0]   count
);

  localparam int CNT_W  = PTR_W + 1;
  localparam int FREE_W = PTR_W + 3;

  // Each entry is {pc, inst}; storage is never cleared, validity comes from count.
  logic [63:0]       mem [DEPTH];

  logic [PTR_W-1:0]  head_reg, head_next;
  logic [PTR_W-1:0]  tail_reg, tail_next;
  logic [CNT_W-1:0]  count_reg, count_next;

  logic [1:0]        push_req;
  logic [1:0]        push_acc;
  logic [1:0]        pop_n;
  logic [FREE_W-1:0] free_space;

  logic [1:0]        wr_en;
  logic [PTR_W-1:0]  wr_addr [2];
  logic [63:0]       wr_data [2];

  logic [1:0]        rd_valid;
  logic [31:0]       rd_pc   [2];
  logic [31:0]       rd_inst [2];

  // Slot 1 only counts when slot 0 is also pushing/popping.
  always_comb begin
    push_req = {1'b0, in_valid_0} + {1'b0, in_valid_0 & in_valid_1};
    pop_n    = {1'b0, pop_0 & rd_valid[0]} + {1'b0, pop_0 & pop_1 & rd_valid[1]};
  end

  // Space freed by this cycle's pops is reusable at the same edge, so a full
  // queue can still take two entries while two leave.
  always_comb begin
    free_space = FREE_W'(DEPTH) - FREE_W'(count_reg) + FREE_W'(pop_n);
    if (FREE_W'(push_req) > free_space) begin
      push_acc = free_space[1:0];
    end else begin
      push_acc = push_req;
    end
  end

  always_comb begin
    wr_en[0]   = (push_acc != 2'd0);
    wr_en[1]   = (push_acc == 2'd2);
    wr_addr[0] = tail_reg;
    wr_addr[1] = tail_reg + PTR_W'(1);
    wr_data[0] = {in_pc_0, in_inst_0};
    wr_data[1] = {in_pc_1, in_inst_1};
  end

  always_comb begin
    head_next  = head_reg + PTR_W'(pop_n);
    tail_next  = tail_reg + PTR_W'(push_acc);
    count_next = count_reg + CNT_W'(push_acc) - CNT_W'(pop_n);
    if (rst || flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    head_reg  <= head_next;
    tail_reg  <= tail_next;
    count_reg <= count_next;
  end

  // Writes are suppressed during reset/flush so that cycle's pushes vanish.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (wr_en[i] && !rst && !flush) begin
        mem[wr_addr[i]] <= wr_data[i];
      end
    end
  end

  // First-word-fall-through read ports at head and head+1.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [PTR_W-1:0] rd_addr;
      logic [63:0]      rd_word;
      assign rd_addr     = head_reg + PTR_W'(gi);
      assign rd_word     = mem[rd_addr];
      assign rd_valid[gi] = (count_reg > CNT_W'(gi));
      assign rd_pc[gi]   = rd_valid[gi] ? rd_word[63:32] : 32'd0;
      assign rd_inst[gi] = rd_valid[gi] ? rd_word[31:0]  : 32'd0;
    end
  endgenerate

  assign out_valid_0 = rd_valid[0];
  assign out_pc_0    = rd_pc[0];
  assign out_inst_0  = rd_inst[0];
  assign out_valid_1 = rd_valid[1];
  assign out_pc_1    = rd_pc[1];
  assign out_inst_1  = rd_inst[1];

  assign almost_full = (count_reg >= CNT_W'(DEPTH - 1));
  assign count       = count_reg;

endmodule

// File: tb/tb_instruction_fifo.sv
// Directed bench for instruction_fifo: one task per scenario, inline checks,
// one line per transaction and a single summary line.
module tb_instruction_fifo;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        in_valid_0, in_valid_1;
  logic [31:0] in_pc_0, in_inst_0, in_pc_1, in_inst_1;
  logic        almost_full;
  logic        out_valid_0, out_valid_1;
  logic [31:0] out_pc_0, out_inst_0, out_pc_1, out_inst_1;
  logic        pop_0, pop_1;
  logic [4:0]  count;

  int checks   = 0;
  int failures = 0;

  instruction_fifo #(.DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid_0(in_valid_0), .in_pc_0(in_pc_0), .in_inst_0(in_inst_0),
    .in_valid_1(in_valid_1), .in_pc_1(in_pc_1), .in_inst_1(in_inst_1),
    .almost_full(almost_full),
    .out_valid_0(out_valid_0), .out_pc_0(out_pc_0), .out_inst_0(out_inst_0),
    .out_valid_1(out_valid_1), .out_pc_1(out_pc_1), .out_inst_1(out_inst_1),
    .pop_0(pop_0), .pop_1(pop_1), .count(count)
  );

  always #5 clk = ~clk;

  // Outputs are sampled 1 time unit after the edge, before inputs change.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; in_valid_0 = 0; in_valid_1 = 0; pop_0 = 0; pop_1 = 0;
    in_pc_0 = 0; in_inst_0 = 0; in_pc_1 = 0; in_inst_1 = 0;
  endtask

  task automatic set_push(input int n, input logic [31:0] pc);
    in_valid_0 = (n >= 1); in_pc_0 = pc;     in_inst_0 = pc ^ 32'hA5A5_0000;
    in_valid_1 = (n >= 2); in_pc_1 = pc + 4; in_inst_1 = (pc + 4) ^ 32'hA5A5_0000;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    $display("reset: count=%0d v0=%0b v1=%0b af=%0b", count, out_valid_0, out_valid_1, almost_full);
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid_0 !== 1'b0 || out_valid_1 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b%0b exp=00", out_valid_0, out_valid_1); end
    checks++; if ({out_pc_0, out_inst_0, out_pc_1, out_inst_1} !== 128'd0) begin failures++; $display("FAIL reset_data got=%h %h %h %h exp=0", out_pc_0, out_inst_0, out_pc_1, out_inst_1); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL reset_af got=%0b exp=0", almost_full); end
  endtask

  task automatic test_ordering();
    in_valid_0 = 1; in_pc_0 = 32'h1000; in_inst_0 = 32'h2402_0001;
    in_valid_1 = 1; in_pc_1 = 32'h1004; in_inst_1 = 32'h2403_0002;
    tick();
    idle_inputs();
    $display("order push2: count=%0d pc0=%h inst0=%h pc1=%h inst1=%h", count, out_pc_0, out_inst_0, out_pc_1, out_inst_1);
    checks++; if (count !== 5'd2) begin failures++; $display("FAIL order_count got=%0d exp=2", count); end
    checks++; if (out_pc_0 !== 32'h1000 || out_inst_0 !== 32'h2402_0001) begin failures++; $display("FAIL order_head got=%h/%h exp=00001000/24020001", out_pc_0, out_inst_0); end
    checks++; if (out_pc_1 !== 32'h1004 || out_inst_1 !== 32'h2403_0002) begin failures++; $display("FAIL order_second got=%h/%h exp=00001004/24030002", out_pc_1, out_inst_1); end
    pop_0 = 1;
    tick();
    idle_inputs();
    $display("order pop1: count=%0d pc0=%h v1=%0b", count, out_pc_0, out_valid_1);
    checks++; if (out_pc_0 !== 32'h1004 || out_inst_0 !== 32'h2403_0002) begin failures++; $display("FAIL order_pop_head got=%h/%h exp=00001004/24030002", out_pc_0, out_inst_0); end
    checks++; if (out_valid_1 !== 1'b0 || out_pc_1 !== 32'd0) begin failures++; $display("FAIL order_pop_v1 got=%0b/%h exp=0/0", out_valid_1, out_pc_1); end
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL order_pop_count got=%0d exp=1", count); end
    pop_0 = 1;
    tick();
    idle_inputs();
    checks++; if (count !== 5'd0 || out_valid_0 !== 1'b0) begin failures++; $display("FAIL order_drain got=%0d/%0b exp=0/0", count, out_valid_0); end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 7; k++) begin
      set_push(2, 32'h2000 + 32'(8 * k));
      tick();
    end
    idle_inputs();
    $display("fill x7: count=%0d af=%0b", count, almost_full);
    checks++; if (count !== 5'd14) begin failures++; $display("FAIL fill14_count got=%0d exp=14", count); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL fill14_af got=%0b exp=0", almost_full); end
    set_push(2, 32'h2038);
    tick();
    idle_inputs();
    $display("fill x8: count=%0d af=%0b", count, almost_full);
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL fill16_count got=%0d exp=16", count); end
    checks++; if (almost_full !== 1'b1) begin failures++; $display("FAIL fill16_af got=%0b exp=1", almost_full); end
    // Deliberate protocol violation: push at full must be dropped.
    set_push(2, 32'h9990);
    tick();
    idle_inputs();
    $display("overflow push: count=%0d pc0=%h pc1=%h", count, out_pc_0, out_pc_1);
    checks++; if (count !== 5'd16) begin failures++; $display("FAIL overflow_count got=%0d exp=16", count); end
    checks++; if (out_pc_0 !== 32'h2000 || out_pc_1 !== 32'h2004) begin failures++; $display("FAIL overflow_head got=%h/%h exp=00002000/00002004", out_pc_0, out_pc_1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_head = 32'h2000;
    logic [31:0] push_pc  = 32'h2040;
    for (int c = 0; c < 20; c++) begin
      $display("b2b cycle %0d: count=%0d pc0=%h pc1=%h", c, count, out_pc_0, out_pc_1);
      checks++; if (count !== 5'd16) begin failures++; $display("FAIL b2b_count c=%0d got=%0d exp=16", c, count); end
      checks++; if (out_pc_0 !== exp_head || out_inst_0 !== (exp_head ^ 32'hA5A5_0000)) begin failures++; $display("FAIL b2b_head c=%0d got=%h/%h exp=%h", c, out_pc_0, out_inst_0, exp_head); end
      checks++; if (out_pc_1 !== exp_head + 4 || out_inst_1 !== ((exp_head + 4) ^ 32'hA5A5_0000)) begin failures++; $display("FAIL b2b_second c=%0d got=%h/%h exp=%h", c, out_pc_1, out_inst_1, exp_head + 4); end
      set_push(2, push_pc);
      pop_0 = 1; pop_1 = 1;
      tick();
      exp_head += 8;
      push_pc  += 8;
    end
    idle_inputs();
    checks++; if (count !== 5'd16 || out_pc_0 !== 32'h20A0 || out_pc_1 !== 32'h20A4) begin failures++; $display("FAIL b2b_final got=%0d/%h/%h exp=16/000020a0/000020a4", count, out_pc_0, out_pc_1); end
  endtask

  task automatic test_flush();
    flush = 1;
    tick();
    idle_inputs();
    set_push(2, 32'h3000); tick();
    set_push(2, 32'h3008); tick();
    set_push(1, 32'h3010); tick();
    idle_inputs();
    $display("flush setup: count=%0d pc0=%h", count, out_pc_0);
    checks++; if (count !== 5'd5 || out_pc_0 !== 32'h3000) begin failures++; $display("FAIL flush_setup got=%0d/%h exp=5/00003000", count, out_pc_0); end
    flush = 1; set_push(2, 32'h3018); pop_0 = 1; pop_1 = 1;
    tick();
    idle_inputs();
    $display("flush: count=%0d v0=%0b pc0=%h", count, out_valid_0, out_pc_0);
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (out_valid_0 !== 1'b0 || out_pc_0 !== 32'd0) begin failures++; $display("FAIL flush_v0 got=%0b/%h exp=0/0", out_valid_0, out_pc_0); end
    set_push(1, 32'h4000);
    tick();
    idle_inputs();
    $display("post-flush push: count=%0d pc0=%h", count, out_pc_0);
    checks++; if (count !== 5'd1 || out_pc_0 !== 32'h4000 || out_valid_1 !== 1'b0) begin failures++; $display("FAIL flush_repush got=%0d/%h/%0b exp=1/00004000/0", count, out_pc_0, out_valid_1); end
  endtask

  task automatic test_illegal();
    pop_0 = 1; pop_1 = 1;
    tick();
    idle_inputs();
    $display("pop2 at count1: count=%0d v0=%0b", count, out_valid_0);
    checks++; if (count !== 5'd0 || out_valid_0 !== 1'b0) begin failures++; $display("FAIL pop_underflow got=%0d/%0b exp=0/0", count, out_valid_0); end
    pop_0 = 1;
    tick();
    idle_inputs();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL pop_empty got=%0d exp=0", count); end
    set_push(1, 32'h5000);
    tick();
    idle_inputs();
    $display("push after empty pop: count=%0d pc0=%h", count, out_pc_0);
    checks++; if (count !== 5'd1 || out_pc_0 !== 32'h5000 || out_inst_0 !== (32'h5000 ^ 32'hA5A5_0000)) begin failures++; $display("FAIL pop_empty_head got=%0d/%h/%h exp=1/00005000", count, out_pc_0, out_inst_0); end
    // Slot 1 without slot 0 is ignored on both the push and pop side.
    in_valid_1 = 1; in_pc_1 = 32'h6000; in_inst_1 = 32'h6666_6666;
    pop_1 = 1;
    tick();
    idle_inputs();
    $display("lone slot1: count=%0d pc0=%h", count, out_pc_0);
    checks++; if (count !== 5'd1 || out_pc_0 !== 32'h5000) begin failures++; $display("FAIL lone_slot1 got=%0d/%h exp=1/00005000", count, out_pc_0); end
    set_push(2, 32'h5004);
    tick();
    idle_inputs();
    checks++; if (count !== 5'd3 || out_pc_1 !== 32'h5004) begin failures++; $display("FAIL lone_slot1_follow got=%0d/%h exp=3/00005004", count, out_pc_1); end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_ordering();
    test_fill();
    test_back_to_back();
    test_flush();
    test_illegal();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fifo.md
# instruction_fifo

Dual-ported instruction queue between the fetch stage and the two decoders in the dual-issue front end. Fetch pushes up to two (PC, instruction) pairs per cycle. The two decode slots read the oldest two entries directly, and issue pops zero, one or two of them per cycle. A pipeline flush (branch redirect, exception) empties the queue in one cycle.

## Interface
- DEPTH, 16: number of entries; power of two, at least 4.
- PTR_W, $clog2(DEPTH): pointer width; the count register is PTR_W+1 bits.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries at this edge.
- in_valid_0  in  1  push slot 0 (older instruction).
- in_pc_0  in  32  PC of slot 0.
- in_inst_0  in  32  instruction word of slot 0.
- in_valid_1  in  1  push slot 1 (younger); legal only together with in_valid_0.
- in_pc_1  in  32  PC of slot 1.
- in_inst_1  in  32  instruction word of slot 1.
- almost_full  out  1  fewer than 2 free entries; fetch must not push while high.
- out_valid_0  out  1  head entry present.
- out_pc_0  out  32  head PC; 0 when out_valid_0=0.
- out_inst_0  out  32  head instruction; 0 when out_valid_0=0.
- out_valid_1  out  1  second entry present.
- out_pc_1  out  32  second PC; 0 when out_valid_1=0.
- out_inst_1  out  32  second instruction; 0 when out_valid_1=0.
- pop_0  in  1  consume the head entry.
- pop_1  in  1  consume the second entry; legal only together with pop_0.
- count  out  PTR_W+1  number of stored entries.

## Operation
State
- Circular storage of DEPTH x 64 bits (PC and instruction).
- Head pointer, tail pointer and count register. Pointers wrap modulo DEPTH.

Push
- push_n = in_valid_0 + (in_valid_0 & in_valid_1).
- Slot 0 is written at tail; slot 1 is written at tail+1.
- in_valid_1 without in_valid_0 is illegal. Slot 1 is ignored in that case.

Pop
- pop_n = (pop_0 & out_valid_0) + (pop_0 & pop_1 & out_valid_1).
- A pop of an invalid slot is ignored.
- pop_1 without pop_0 is ignored.
- Head advances by pop_n.

Count and flags
- Next count = count + push_n − pop_n.
- Overflow protection: when push_n exceeds DEPTH − count + pop_n, slots are accepted oldest-first up to the available space. The excess is silently dropped. This is a protocol violation and the bench flags it.
- almost_full = (DEPTH − count) < 2. It is derived from the registered count only.
- out_valid_0 = (count ≥ 1); out_valid_1 = (count ≥ 2).
- Outputs are first-word-fall-through reads at head and head+1, with data forced to 0 when the slot is invalid.

Flush and reset
- Flush has priority over push and pop in the same cycle. Next head = tail = count = 0, and that cycle's pushes are discarded.
- Reset has the same effect as flush. Storage contents are not cleared.

## Timing
- Reset values:
  - count = 0, almost_full = 0.
  - out_valid_0/1 = 0.
  - out_pc_0/1 = 0, out_inst_0/1 = 0.
- Push-to-visible latency is 1 cycle: an entry pushed at edge N appears on out_* after edge N.
- No bypass from in_* to out_* in the same cycle.
- Pop takes effect at the edge. The next entries appear in the following cycle.
- Simultaneous push and pop are fully supported at any occupancy, including count = DEPTH with pop_n = 2 and push_n = 2.
- Wrap-around is transparent. Slot 1 of a push or pop may straddle index DEPTH−1 to 0.
- The fetch stage samples almost_full in the same cycle it pushes. The block needs no extra skid slots.
- Throughput is 2 entries per cycle sustained in and out.

## Test plan
- Reset then idle: assert rst for 2 cycles → count = 0, out_valid_0/1 = 0, all out data 0, almost_full = 0.
- Ordering: push (0x1000, 0x24020001) and (0x1004, 0x24030002) in one cycle, no pop → next cycle count = 2 and out_pc_0 = 0x1000, out_pc_1 = 0x1004 with matching instructions. Then pop_0 only → out_pc_0 = 0x1004, out_valid_1 = 0.
- Fill and almost_full: DEPTH=16, push 2 per cycle for 7 cycles → count = 14, almost_full = 0. One more 2-push → count = 16, almost_full = 1. Pushing 2 more at full is dropped → count stays 16.
- Wrap and concurrency: at count = 16, push 2 and pop 2 each cycle for 20 cycles with incrementing PCs → count stays 16, output PCs strictly increase by 4, no gaps or duplicates across the index 15→0 wrap.
- Flush priority: count = 5, assert flush together with a 2-push and a 2-pop → next cycle count = 0, out_valid_0 = 0. A push in the following cycle appears at out_pc_0.
- Illegal pops: count = 1, assert pop_0 and pop_1 → count = 0 with no underflow. With count = 0, pop_0 leaves count = 0 and the head pointer unchanged, verified by a subsequent push appearing correctly.
